// File: rtl/gpio_in_port.sv
// Debounced memory-mapped input port: synchronizes pins, latches rising edges
// into clear-on-read flags and raises a maskable level interrupt.
module gpio_in_port #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] gpio_i,
  input  logic             rd_en_i,
  input  logic             wr_en_i,
  input  logic [1:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             rvalid_o,
  output logic             irq_o
);

  localparam int unsigned    CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_LEVEL = 2'd0;
  localparam logic [1:0] ADDR_EDGE  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;

  logic [WIDTH-1:0]         s1, s2, db, db_next;
  logic [WIDTH-1:0]         edge_q, edge_next, mask_q;
  logic [WIDTH-1:0][CW-1:0] cnt, cnt_next;
  logic                     edge_clear;
  logic [31:0]              rd_word;
  logic                     unused_wdata;

  // Only the low WIDTH bits of a MASK write are kept.
  assign unused_wdata = ^wdata_i;

  always_comb begin
    db_next  = db;
    cnt_next = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s2[i] != db[i]) begin
        if (cnt[i] == CNT_MAX) begin
          db_next[i] = s2[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // A rise landing on the clearing read's edge survives the clear.
  always_comb begin
    edge_clear = rd_en_i && (addr_i == ADDR_EDGE);
    edge_next  = (edge_q & ~{WIDTH{edge_clear}}) | (db_next & ~db);
  end

  always_comb begin
    rd_word = '0;
    case (addr_i)
      ADDR_LEVEL: rd_word = 32'(db);
      ADDR_EDGE:  rd_word = 32'(edge_q);
      ADDR_MASK:  rd_word = 32'(mask_q);
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      s1       <= '0;
      s2       <= '0;
      db       <= '0;
      cnt      <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      s1       <= gpio_i;
      s2       <= s1;
      db       <= db_next;
      cnt      <= cnt_next;
      edge_q   <= edge_next;
      rvalid_o <= rd_en_i;
      if (rd_en_i) begin
        rdata_o <= rd_word;
      end
      if (wr_en_i && (addr_i == ADDR_MASK)) begin
        mask_q <= wdata_i[WIDTH-1:0];
      end
      irq_o <= |(edge_q & mask_q);
    end
  end

endmodule

// File: tb/tb_gpio_in_port.sv
// Directed bench for gpio_in_port: register-map vector table plus hand-built
// debounce, edge, interrupt and reset sequences.
module tb_gpio_in_port;

  logic        clk;
  logic        reset_n;
  logic [7:0]  gpio;
  logic        rd_en;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  int errors = 0;
  int checks = 0;

  gpio_in_port #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_n),
    .gpio_i   (gpio),
    .rd_en_i  (rd_en),
    .wr_en_i  (wr_en),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rdata_o  (rdata),
    .rvalid_o (rvalid),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_rvalid;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    rd_en = 1'b1;
    addr  = a;
    tick();
    rd_en = 1'b0;
    check({name, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    check(name, rdata, exp);
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 32'h0,        32'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd3, 32'h0,        32'h00, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 2'd2, 32'hFFFFFFA5, 32'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'hA5, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 2'd2, 32'h0000003C, 32'hA5, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h3C, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 32'hFF,       32'h3C, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'd1, 32'hFF,       32'h3C, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'd3, 32'hFF,       32'h3C, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h00, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'd1, 32'h0,        32'h00, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 2'd3, 32'h0,        32'h00, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 2'd2, 32'h0,        32'h3C, 1'b1, 1'b0};

    reset_n = 1'b0;
    gpio    = '0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    addr    = '0;
    wdata   = '0;
    repeat (3) tick();
    check("reset_rdata", rdata, 32'h0);
    check("reset_rvalid", {31'd0, rvalid}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;

    // Register map; the last vector also clears MASK back to 0.
    for (int i = 0; i < 15; i++) begin
      rd_en = vecs[i].rd;
      wr_en = vecs[i].wr;
      addr  = vecs[i].addr;
      wdata = vecs[i].wdata;
      tick();
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_rvalid", i), {31'd0, rvalid}, {31'd0, vecs[i].exp_rvalid});
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    read_chk("mask_cleared", 2'd2, 32'h0);

    // Debounce latency: pins first sampled at edge 0, db updates at edge 17.
    gpio = 8'h05;
    repeat (16) tick();
    read_chk("level_e16", 2'd0, 32'h00);
    read_chk("level_e17", 2'd0, 32'h00);
    read_chk("level_e18", 2'd0, 32'h05);
    read_chk("edge_first", 2'd1, 32'h05);
    read_chk("edge_second", 2'd1, 32'h00);
    check("irq_unmasked", {31'd0, irq}, 32'd0);
    gpio = 8'h00;
    repeat (22) tick();
    read_chk("level_fall", 2'd0, 32'h00);
    read_chk("edge_fall", 2'd1, 32'h00);

    // Short glitch is rejected even with every bit unmasked.
    write_reg(2'd2, 32'hFF);
    gpio = 8'h08;
    repeat (10) tick();
    gpio = 8'h00;
    for (int i = 0; i < 25; i++) begin
      tick();
      check($sformatf("glitch_irq%0d", i), {31'd0, irq}, 32'd0);
    end
    read_chk("glitch_level", 2'd0, 32'h00);
    read_chk("glitch_edge", 2'd1, 32'h00);

    // Exactly DEBOUNCE_CYCLES-long pulse is accepted.
    gpio = 8'h08;
    repeat (16) tick();
    gpio = 8'h00;
    repeat (30) tick();
    check("pulse16_irq", {31'd0, irq}, 32'd1);
    read_chk("pulse16_edge", 2'd1, 32'h08);
    check("pulse16_irq_after_read", {31'd0, irq}, 32'd1);
    tick();
    check("pulse16_irq_fall", {31'd0, irq}, 32'd0);

    // Masked interrupt on bit 1.
    write_reg(2'd2, 32'h02);
    gpio = 8'h02;
    repeat (18) tick();
    check("irq_same_edge_as_flag", {31'd0, irq}, 32'd0);
    tick();
    check("irq_one_after_flag", {31'd0, irq}, 32'd1);
    read_chk("irq_edge_read", 2'd1, 32'h02);
    check("irq_hold_read_edge", {31'd0, irq}, 32'd1);
    tick();
    check("irq_fall_after_read", {31'd0, irq}, 32'd0);
    gpio = 8'h03;
    repeat (25) tick();
    check("irq_masked_bit0", {31'd0, irq}, 32'd0);
    read_chk("edge_bit0", 2'd1, 32'h01);

    // Rise on bit 2 coincides with the read that clears bit 0.
    gpio = 8'h00;
    repeat (25) tick();
    read_chk("edge_clear_pre", 2'd1, 32'h00);
    gpio = 8'h01;
    repeat (20) tick();
    gpio = 8'h05;
    repeat (17) tick();
    read_chk("edge_race_read", 2'd1, 32'h01);
    read_chk("edge_race_next", 2'd1, 32'h04);

    // Reset mid-debounce and mid-read.
    gpio = 8'h00;
    repeat (25) tick();
    gpio = 8'h10;
    repeat (12) tick();
    rd_en   = 1'b1;
    addr    = 2'd0;
    reset_n = 1'b0;
    tick();
    rd_en   = 1'b0;
    reset_n = 1'b1;
    check("rst_mid_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_mid_rdata", rdata, 32'h0);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    read_chk("rst_mask", 2'd2, 32'h00);
    read_chk("rst_edge", 2'd1, 32'h00);
    repeat (15) tick();
    read_chk("rst_level_early", 2'd0, 32'h00);
    read_chk("rst_level_late", 2'd0, 32'h10);
    read_chk("rst_edge_bit4", 2'd1, 32'h10);
    tick();
    check("rvalid_drop", {31'd0, rvalid}, 32'd0);
    check("rdata_hold", rdata, 32'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
